// File: rtl/ws2812_pkg.sv
// Shared state encodings and bit-timing helper for the WS2812 chain driver.
package ws2812_pkg;

   localparam int unsigned T0H_NS    = 350;
   localparam int unsigned T1H_NS    = 700;
   localparam int unsigned TBIT_NS   = 1250;
   localparam int unsigned TLATCH_NS = 80000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SEND  = 2'b10,
      ST_LATCH = 2'b11
   } chain_state_t;

   // Bit 0 of the phase is 1 only in PH_HIGH, so it drives the line straight from a flop.
   typedef enum logic [1:0] {
      PH_IDLE = 2'b00,
      PH_HIGH = 2'b01,
      PH_LOW  = 2'b10
   } bit_phase_t;

   function automatic int unsigned ns_to_cycles(input longint unsigned clk_hz,
                                                input longint unsigned ns);
      longint unsigned prod;
      prod = clk_hz * ns + 64'd500_000_000;
      return 32'(prod / 64'd1_000_000_000);
   endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Serialises one 24-bit GRB word MSB first as WS2812 HIGH/LOW pulse pairs.
module ws2812_bit_tx
   import ws2812_pkg::*;
#(
   parameter int unsigned T0H  = 15,
   parameter int unsigned T1H  = 30,
   parameter int unsigned TBIT = 54
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [23:0] word,
   output logic        line,
   output logic        done
);

   localparam int unsigned CNT_W = $clog2(TBIT + 1);

   bit_phase_t       phase, phase_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [23:0]      shreg, shreg_nx;
   logic [4:0]       bit_cnt, bit_cnt_nx;
   logic             first, first_nx;

   function automatic logic [CNT_W-1:0] high_len(input logic b);
      return b ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
   endfunction

   // The top's LOAD cycle precedes the first bit, so that bit's low phase is one cycle shorter.
   function automatic logic [CNT_W-1:0] low_len(input logic b, input logic shortened);
      if (b)
         return shortened ? CNT_W'(TBIT - T1H - 2) : CNT_W'(TBIT - T1H - 1);
      return shortened ? CNT_W'(TBIT - T0H - 2) : CNT_W'(TBIT - T0H - 1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset)
         phase <= PH_IDLE;
      else
         phase <= phase_nx;
      cnt     <= cnt_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      first   <= first_nx;
   end

   always_comb begin
      phase_nx   = phase;
      cnt_nx     = cnt;
      shreg_nx   = shreg;
      bit_cnt_nx = bit_cnt;
      first_nx   = first;
      done       = 1'b0;
      case (phase)
         PH_IDLE: begin
            if (load) begin
               phase_nx   = PH_HIGH;
               shreg_nx   = word;
               bit_cnt_nx = 5'd23;
               first_nx   = 1'b1;
               cnt_nx     = high_len(word[23]);
            end
         end
         PH_HIGH: begin
            if (cnt == '0) begin
               phase_nx = PH_LOW;
               cnt_nx   = low_len(shreg[23], first);
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         PH_LOW: begin
            if (cnt != '0) begin
               cnt_nx = cnt - CNT_W'(1);
            end else if (bit_cnt == 5'd0) begin
               done     = 1'b1;
               phase_nx = PH_IDLE;
            end else begin
               phase_nx   = PH_HIGH;
               shreg_nx   = {shreg[22:0], 1'b0};
               bit_cnt_nx = bit_cnt - 5'd1;
               first_nx   = 1'b0;
               cnt_nx     = high_len(shreg[22]);
            end
         end
         default: phase_nx = PH_IDLE;
      endcase
   end

   assign line = phase[0];

endmodule

// File: rtl/ip_ws2812_chain.sv
// WS2812 daisy-chain driver: colour buffer, frame sequencing and latch gap.
// Optional macro WS2812_BRIGHTNESS_EN scales each channel by (brightness+1)/256.
module ip_ws2812_chain
   import ws2812_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 42_954_540,
   parameter int unsigned LED_COUNT = 8,
   parameter int unsigned IDX_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [IDX_W-1:0] index,
   input  logic [7:0]       red,
   input  logic [7:0]       green,
   input  logic [7:0]       blue,
   input  logic             start,
   input  logic [7:0]       brightness,
   output logic             busy,
   output logic             ws2812_led
);

   localparam int unsigned T0H_CYC    = ns_to_cycles(64'(CLK_FREQ), 64'(T0H_NS));
   localparam int unsigned T1H_CYC    = ns_to_cycles(64'(CLK_FREQ), 64'(T1H_NS));
   localparam int unsigned TBIT_CYC   = ns_to_cycles(64'(CLK_FREQ), 64'(TBIT_NS));
   localparam int unsigned TLATCH_CYC = ns_to_cycles(64'(CLK_FREQ), 64'(TLATCH_NS));
   localparam int unsigned AW         = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
   localparam int unsigned LAT_W      = $clog2(TLATCH_CYC + 1);
   localparam logic [AW-1:0]  LAST_LED  = AW'(LED_COUNT - 1);
   localparam logic [IDX_W:0] LED_LIMIT = (IDX_W + 1)'(LED_COUNT);

   chain_state_t     state, state_nx;
   logic [AW-1:0]    led_idx, led_idx_nx;
   logic             pending, pending_nx;
   logic [LAT_W-1:0] lat_cnt, lat_cnt_nx;
   logic             busy_q;
   logic             clearing;
   logic [AW-1:0]    clr_idx;
   logic [23:0]      buf_mem [0:(1 << AW) - 1];
   logic             wr_ok;
   logic [AW-1:0]    wr_addr;
   logic [23:0]      raw_word;
   logic [23:0]      tx_word;
   logic             tx_load;
   logic             tx_done;

   assign wr_ok   = wr && !reset && ({1'b0, index} < LED_LIMIT);
   assign wr_addr = index[AW-1:0];

   // One write port: host writes win; the post-reset clear walk pauses for them.
   always_ff @(posedge clk) begin
      if (wr_ok)
         buf_mem[wr_addr] <= {green, red, blue};
      else if (clearing)
         buf_mem[clr_idx] <= '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clearing <= 1'b1;
         clr_idx  <= '0;
      end else if (clearing && !wr_ok) begin
         if (clr_idx == LAST_LED)
            clearing <= 1'b0;
         clr_idx <= clr_idx + AW'(1);
      end
   end

   assign raw_word = buf_mem[led_idx];

`ifdef WS2812_BRIGHTNESS_EN
   function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod = {8'd0, c} * ({8'd0, b} + 16'd1);
      return 8'(prod >> 8);
   endfunction

   assign tx_word = {scale_chan(raw_word[23:16], brightness),
                     scale_chan(raw_word[15:8],  brightness),
                     scale_chan(raw_word[7:0],   brightness)};
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign tx_word           = raw_word;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         led_idx <= '0;
         pending <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         led_idx <= led_idx_nx;
         pending <= pending_nx;
         busy_q  <= (state_nx != ST_IDLE);
      end
      lat_cnt <= lat_cnt_nx;
   end

   always_comb begin
      state_nx   = state;
      led_idx_nx = led_idx;
      pending_nx = pending;
      lat_cnt_nx = lat_cnt;
      tx_load    = 1'b0;
      if (start && state != ST_IDLE)
         pending_nx = 1'b1;
      case (state)
         ST_IDLE: begin
            if (start || pending) begin
               state_nx   = ST_LOAD;
               led_idx_nx = '0;
               pending_nx = 1'b0;
            end
         end
         ST_LOAD: begin
            tx_load  = 1'b1;
            state_nx = ST_SEND;
         end
         ST_SEND: begin
            if (tx_done) begin
               if (led_idx == LAST_LED) begin
                  state_nx   = ST_LATCH;
                  lat_cnt_nx = LAT_W'(TLATCH_CYC - 1);
               end else begin
                  led_idx_nx = led_idx + AW'(1);
                  state_nx   = ST_LOAD;
               end
            end
         end
         ST_LATCH: begin
            if (lat_cnt == '0)
               state_nx = ST_IDLE;
            else
               lat_cnt_nx = lat_cnt - LAT_W'(1);
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy = busy_q;

   ws2812_bit_tx #(
      .T0H  (T0H_CYC),
      .T1H  (T1H_CYC),
      .TBIT (TBIT_CYC)
   ) u_bit_tx (
      .clk   (clk),
      .reset (reset),
      .load  (tx_load),
      .word  (tx_word),
      .line  (ws2812_led),
      .done  (tx_done)
   );

endmodule
